// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher for a registered-read ROM, with jump flush.
// Optional starvation counter enabled by defining FETCH_STARVE_CNT_EN.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  output logic [DATA_WIDTH-1:0] INSTR_DATA,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  JUMP_EN,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  output logic [15:0]           STARVE_CNT
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [ADDR_WIDTH-1:0] r_head_addr;

  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [OW-1:0]         w_occ;
  logic [PW-1:0]         w_rptr_nxt;
  logic [CW-1:0]         w_count_left;
  logic [CW-1:0]         w_count_nxt;

  always_comb begin
    w_pop        = r_valid & INSTR_READY & ~JUMP_EN;
    w_push       = r_pending & ~JUMP_EN;
    // Credit check counts the in-flight read so a full buffer can never be overrun.
    w_occ        = OW'(r_count) + OW'(r_pending) - OW'(w_pop);
    w_issue      = w_occ < OW'(DEPTH);
    w_rptr_nxt   = r_rptr + PW'(w_pop);
    w_count_left = r_count - CW'(w_pop);
    w_count_nxt  = w_count_left + CW'(w_push);
    if (!RESETn) begin
      w_rom_addr = '0;
    end else if (JUMP_EN) begin
      w_rom_addr = JUMP_ADDR;
    end else begin
      w_rom_addr = r_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_pc        <= '0;
      r_pend_addr <= '0;
      r_pending   <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_head_data <= '0;
      r_head_addr <= '0;
    end else begin
      if (JUMP_EN || w_issue) begin
        r_pc        <= w_rom_addr + ADDR_WIDTH'(1);
        r_pending   <= 1'b1;
        r_pend_addr <= w_rom_addr;
      end else begin
        r_pending   <= 1'b0;
      end

      if (JUMP_EN) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem_data[r_wptr] <= ROM_DATA;
          r_mem_addr[r_wptr] <= r_pend_addr;
          r_wptr             <= r_wptr + PW'(1);
        end
        r_rptr  <= w_rptr_nxt;
        r_count <= w_count_nxt;
        r_valid <= (w_count_nxt != '0);
        // Bypass the incoming word when it lands in an otherwise empty buffer.
        if (w_push && (w_count_left == '0)) begin
          r_head_data <= ROM_DATA;
          r_head_addr <= r_pend_addr;
        end else if (w_count_nxt != '0) begin
          r_head_data <= r_mem_data[w_rptr_nxt];
          r_head_addr <= r_mem_addr[w_rptr_nxt];
        end
      end
    end
  end

  assign ROM_ADDR    = w_rom_addr;
  assign INSTR_DATA  = r_head_data;
  assign INSTR_ADDR  = r_head_addr;
  assign INSTR_VALID = r_valid;

`ifdef FETCH_STARVE_CNT_EN
  logic [15:0] r_starve;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_starve <= '0;
    end else if (INSTR_READY && !r_valid && (r_starve != 16'hFFFF)) begin
      r_starve <= r_starve + 16'd1;
    end
  end

  assign STARVE_CNT = r_starve;
`else
  assign STARVE_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand-written stall,
// jump and mid-stream reset sequences. ROM returns addr^0x5A one cycle late.
module tb_instr_fetch_unit;

`ifdef FETCH_STARVE_CNT_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  instr_data;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic [15:0] starve_cnt;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .DEPTH     (4)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .ROM_ADDR   (rom_addr),
    .ROM_DATA   (rom_data),
    .INSTR_DATA (instr_data),
    .INSTR_ADDR (instr_addr),
    .INSTR_VALID(instr_valid),
    .INSTR_READY(instr_ready),
    .JUMP_EN    (jump_en),
    .JUMP_ADDR  (jump_addr),
    .STARVE_CNT (starve_cnt)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) rom_data <= rom_addr ^ 8'h5A;

  typedef struct {
    logic        ready;
    logic        jump;
    logic [7:0]  jaddr;
    logic        exp_valid;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
    logic [7:0]  exp_rom;
    logic [15:0] exp_starve;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESETn      = 1'b0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    tick();
    tick();
    RESETn = 1'b1;
  endtask

  initial begin
    bit found;

    //        ready jump jaddr  vld addr   data   rom    starve
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 16'd1};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h5A, 8'h02, 16'd2};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h5B, 8'h03, 16'd2};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58, 8'h04, 16'd2};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'h59, 8'h05, 16'd2};
    vecs[6]  = '{1'b1, 1'b1, 8'hFE, 1'b1, 8'h04, 8'h5E, 8'hFE, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 8'hA4, 8'h00, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hA5, 8'h01, 16'd3};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h5A, 8'h02, 16'd3};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h5B, 8'h03, 16'd3};

    // Reset state, observed while reset is asserted.
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("reset_instr_addr", {24'd0, instr_addr}, 32'd0);
    chk("reset_instr_data", {24'd0, instr_data}, 32'd0);
    chk("reset_starve", {16'd0, starve_cnt}, 32'd0);

    // Streaming from reset, then jump to 0xFE and wrap.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      instr_ready = vecs[i].ready;
      jump_en     = vecs[i].jump;
      jump_addr   = vecs[i].jaddr;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("tbl%0d_rom_addr", i), {24'd0, rom_addr}, {24'd0, vecs[i].exp_rom});
      chk($sformatf("tbl%0d_starve", i), {16'd0, starve_cnt},
          StarveOn ? {16'd0, vecs[i].exp_starve} : 32'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("tbl%0d_addr", i), {24'd0, instr_addr}, {24'd0, vecs[i].exp_addr});
        chk($sformatf("tbl%0d_data", i), {24'd0, instr_data}, {24'd0, vecs[i].exp_data});
      end
      tick();
    end
    jump_en = 1'b0;

    // Consumer stalled from reset: only 0x00..0x03 issued, then drain back-to-back.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("stall_c%0d_rom", c), {24'd0, rom_addr}, (c < 4) ? c : 32'd4);
      if (c >= 2) begin
        chk($sformatf("stall_c%0d_valid", c), {31'd0, instr_valid}, 32'd1);
        chk($sformatf("stall_c%0d_addr", c), {24'd0, instr_addr}, 32'd0);
      end
      tick();
    end
    instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("drain%0d_valid", c), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("drain%0d_addr", c), {24'd0, instr_addr}, c);
      chk($sformatf("drain%0d_data", c), {24'd0, instr_data}, c ^ 32'h5A);
      tick();
    end

    // Jump while streaming with head at 0x10.
    do_reset();
    instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (instr_valid && instr_addr == 8'h10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("jump_reach_0x10", {31'd0, found}, 32'd1);
    jump_en   = 1'b1;
    jump_addr = 8'h80;
    #1;
    chk("jump_rom_addr", {24'd0, rom_addr}, 32'h80);
    tick();
    jump_en   = 1'b0;
    jump_addr = 8'h00;
    #1;
    chk("jump_flush_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    #1;
    chk("jump_tgt_valid", {31'd0, instr_valid}, 32'd1);
    chk("jump_tgt_addr", {24'd0, instr_addr}, 32'h80);
    chk("jump_tgt_data", {24'd0, instr_data}, 32'hDA);
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1;
      chk($sformatf("jump_stale%0d", k),
          {31'd0, instr_valid && instr_addr >= 8'h11 && instr_addr <= 8'h14}, 32'd0);
      chk($sformatf("jump_seq%0d_addr", k), {24'd0, instr_addr}, 32'h80 + k);
    end

    // One-cycle reset with the buffer full.
    do_reset();
    for (int c = 0; c < 7; c++) tick();
    RESETn = 1'b0;
    #1;
    chk("rst_full_rom_in_reset", {24'd0, rom_addr}, 32'd0);
    tick();
    RESETn      = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("rst_full_valid0", {31'd0, instr_valid}, 32'd0);
    chk("rst_full_rom0", {24'd0, rom_addr}, 32'd0);
    tick();
    #1;
    chk("rst_full_valid1", {31'd0, instr_valid}, 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rst_full_c%0d_valid", c + 2), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("rst_full_c%0d_addr", c + 2), {24'd0, instr_addr}, c);
      chk($sformatf("rst_full_c%0d_data", c + 2), {24'd0, instr_data}, c ^ 32'h5A);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
